// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and codes for the elevator floor scheduler
package elevator_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // Committed travel direction codes
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int FLOORS_DEFAULT = 9;

  // Floor numbers are 1-based binary values
  typedef logic [4:0] floor_t;

endpackage

// File: rtl/request_latch.sv
// rtl/request_latch.sv - button edge detect and pending request set with clear priority
module request_latch
  import elevator_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEFAULT,
  parameter int IW     = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] push_btns,
  input  logic              clr_en,
  input  logic [IW-1:0]     clr_idx,
  output logic [FLOORS-1:0] press,
  output logic [FLOORS-1:0] pending
);

  logic [FLOORS-1:0] prev;
  logic [FLOORS-1:0] clr_mask;

  // Rising edges of the raw buttons; one-hot decode of the clear request
  always_comb begin
    press    = push_btns & ~prev;
    clr_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      clr_mask[i] = clr_en && (clr_idx == IW'(i));
    end
  end

  // Track button history and accumulate requests; a clear beats a same-cycle set
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= push_btns;
      pending <= (pending | press) & ~clr_mask;
    end
  end

endmodule

// File: rtl/elevator_floor_scheduler.sv
// rtl/elevator_floor_scheduler.sv - SCAN car-motion scheduler with travel and door timing
module elevator_floor_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS      = FLOORS_DEFAULT,
  parameter int MOVE_CYCLES = 50,
  parameter int DOOR_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] push_btns,
  output logic [FLOORS-1:0] pending,
  output logic [4:0]        current,
  output logic [1:0]        direction,
  output logic              moving,
  output logic              door_open,
  output logic              arrive
);

  localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(FLOORS);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
  localparam floor_t TOP_FLOOR = floor_t'(FLOORS);

  state_t            state;
  logic [TW-1:0]     timer;
  logic [FLOORS-1:0] press;
  logic              clr_en;
  logic [IW-1:0]     clr_idx;
  logic              above, below, above_next, below_next;
  logic              pend_here, press_here, pend_up, pend_dn;
  logic              move_done;

  request_latch #(.FLOORS(FLOORS), .IW(IW)) u_latch (
    .clk       (clk),
    .rst       (rst),
    .push_btns (push_btns),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .press     (press),
    .pending   (pending)
  );

  // Request geometry relative to the car and to the floor it is about to reach
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    above_next = 1'b0;
    below_next = 1'b0;
    pend_here  = 1'b0;
    press_here = 1'b0;
    pend_up    = 1'b0;
    pend_dn    = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && floor_t'(i + 1) > current)           above      = 1'b1;
      if (pending[i] && floor_t'(i + 1) < current)           below      = 1'b1;
      if (pending[i] && floor_t'(i + 1) > current + 5'd1)    above_next = 1'b1;
      if (pending[i] && floor_t'(i + 2) < current)           below_next = 1'b1;
      if (pending[i] && floor_t'(i + 1) == current)          pend_here  = 1'b1;
      if (press[i]   && floor_t'(i + 1) == current)          press_here = 1'b1;
      if (pending[i] && floor_t'(i + 1) == current + 5'd1)   pend_up    = 1'b1;
      if (pending[i] && floor_t'(i + 2) == current)          pend_dn    = 1'b1;
    end
    move_done = (timer == MOVE_LAST);
  end

  // Clear the floor being served: continuously while parked, and at the arrival edge of a stop
  always_comb begin
    clr_en  = 1'b0;
    clr_idx = IW'(current - 5'd1);
    case (state)
      IDLE, DOOR_OPEN: clr_en = 1'b1;
      MOVE_UP: begin
        if (move_done && pend_up) begin
          clr_en  = 1'b1;
          clr_idx = IW'(current);
        end
      end
      MOVE_DOWN: begin
        if (move_done && pend_dn) begin
          clr_en  = 1'b1;
          clr_idx = IW'(current - 5'd2);
        end
      end
      default: ;
    endcase
  end

  // Scheduler FSM with shared travel/dwell timer and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      current   <= 5'd1;
      direction <= DIR_NONE;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
    end else begin
      arrive <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (pend_here || press_here) begin
            state     <= DOOR_OPEN;
            door_open <= 1'b1;
          end else if (above && (direction != DIR_DOWN || !below)) begin
            state     <= MOVE_UP;
            direction <= DIR_UP;
            moving    <= 1'b1;
          end else if (below) begin
            state     <= MOVE_DOWN;
            direction <= DIR_DOWN;
            moving    <= 1'b1;
          end else begin
            direction <= DIR_NONE;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (move_done) begin
            timer  <= '0;
            arrive <= 1'b1;
            current <= (state == MOVE_UP) ? current + 5'd1 : current - 5'd1;
            if ((state == MOVE_UP) ? pend_up : pend_dn) begin
              state     <= DOOR_OPEN;
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (!((state == MOVE_UP) ? above_next : below_next)) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DOOR_OPEN: begin
          if (press_here) begin
            timer <= '0;
          end else if (timer == DOOR_LAST) begin
            timer     <= '0;
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The policy must never drive the car past either end of the shaft
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(state == MOVE_UP && current >= TOP_FLOOR));
      assert (!(state == MOVE_DOWN && current <= 5'd1));
    end
  end

endmodule

// File: tb/tb_elevator_floor_scheduler.sv
// tb/tb_elevator_floor_scheduler.sv - directed self-checking bench for the elevator scheduler
module tb_elevator_floor_scheduler;

  localparam int FL = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FL-1:0] push_btns = '0;
  logic [FL-1:0] pending;
  logic [4:0]    current;
  logic [1:0]    direction;
  logic          moving;
  logic          door_open;
  logic          arrive;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_floor_scheduler #(
    .FLOORS      (FL),
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_btns (push_btns),
    .pending   (pending),
    .current   (current),
    .direction (direction),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive)
  );

  function automatic logic [FL-1:0] fm(input int f);
    logic [FL-1:0] one;
    one = FL'(1);
    return one << (f - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [FL-1:0] m);
    push_btns = m;
    @(negedge clk);
    push_btns = '0;
  endtask

  task automatic wait_open(output int fl, output int dir);
    int g;
    g = 0;
    while (!door_open && g < 400) begin
      @(negedge clk);
      g++;
    end
    fl  = door_open ? int'(current) : 0;
    dir = int'(direction);
  endtask

  task automatic wait_close();
    int g;
    g = 0;
    while (door_open && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("door_close_timeout", door_open, 0);
  endtask

  task automatic wait_floor(input int f);
    int g;
    g = 0;
    while (int'(current) != f && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("reach_floor", current, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fl;
    int dir;
    logic pend_any;
    logic saw;

    // reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pending", pending, 0);
    chk("rst_current", current, 1);
    chk("rst_direction", direction, 0);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_arrive", arrive, 0);
    rst = 1'b0;

    // single up-trip 1 -> 3
    press(fm(3));
    chk("s1_pending", pending, fm(3));
    @(negedge clk);
    chk("s1_moving", moving, 1);
    chk("s1_dir_up", direction, 1);
    repeat (3) @(negedge clk);
    chk("s1_pre_arrive", arrive, 0);
    chk("s1_pre_current", current, 1);
    @(negedge clk);
    chk("s1_arrive2", arrive, 1);
    chk("s1_current2", current, 2);
    repeat (4) @(negedge clk);
    chk("s1_arrive3", arrive, 1);
    chk("s1_current3", current, 3);
    chk("s1_door", door_open, 1);
    chk("s1_pend_clr", pending, 0);
    n = 0;
    while (door_open && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("s1_door_len", n, 6);
    @(negedge clk);
    chk("s1_dir_none", direction, 0);
    chk("s1_idle_moving", moving, 0);

    // same-floor press with dwell restart at count 4
    press(fm(3));
    chk("s2_door_open", door_open, 1);
    n = 0;
    pend_any = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (door_open) n++;
      if (pending != '0) pend_any = 1'b1;
      push_btns = (i == 4) ? fm(3) : '0;
      @(negedge clk);
    end
    push_btns = '0;
    chk("s2_door_len", n, 11);
    chk("s2_pend_zero", pend_any, 0);

    // SCAN: reach 5 travelling down, then 7 and 2 pressed together
    press(fm(6));
    wait_open(fl, dir);
    chk("s3_at6", fl, 6);
    wait_close();
    press(fm(5));
    wait_open(fl, dir);
    chk("s3_at5", fl, 5);
    chk("s3_dir5", dir, 2);
    press(fm(7) | fm(2));
    chk("s3_both_pending", pending, fm(7) | fm(2));
    wait_close();
    wait_open(fl, dir);
    chk("s3_first2", fl, 2);
    chk("s3_dir2", dir, 2);
    wait_close();
    wait_open(fl, dir);
    chk("s3_then7", fl, 7);
    chk("s3_dir7", dir, 1);
    wait_close();

    // mid-trip requests: down from 7 toward 1, add 4 (ahead) and 9 (behind)
    press(fm(1));
    wait_floor(6);
    press(fm(4) | fm(9));
    wait_open(fl, dir);
    chk("s4_stop4", fl, 4);
    wait_close();
    wait_open(fl, dir);
    chk("s4_stop1", fl, 1);
    wait_close();
    wait_open(fl, dir);
    chk("s4_stop9", fl, 9);
    chk("s4_dir9", dir, 1);
    wait_close();

    // edge-only capture: floor 6 held for 30 cycles
    push_btns = fm(6);
    @(negedge clk);
    chk("s5_one_req", pending, fm(6));
    saw = 1'b0;
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (door_open && current == 5'd6) saw = 1'b1;
    end
    chk("s5_served6", saw, 1);
    chk("s5_no_rereq", pending, 0);
    chk("s5_idle_door", door_open, 0);
    chk("s5_idle_moving", moving, 0);
    push_btns = '0;
    repeat (3) @(negedge clk);
    chk("s5_release", pending, 0);
    press(fm(6));
    chk("s5_repress_door", door_open, 1);
    chk("s5_repress_pend", pending, 0);
    wait_close();

    // reset in the middle of a move between 3 and 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_home", current, 1);
    press(fm(5));
    wait_floor(3);
    repeat (2) @(negedge clk);
    chk("s6_midmove", moving, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_current", current, 1);
    chk("s6_pending", pending, 0);
    chk("s6_moving", moving, 0);
    chk("s6_door", door_open, 0);
    chk("s6_direction", direction, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("s6_stay_idle", moving, 0);
    chk("s6_stay_floor", current, 1);

    // button held through reset counts as a press right after reset
    rst = 1'b1;
    push_btns = fm(2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s7_held_press", pending, fm(2));
    push_btns = '0;
    wait_open(fl, dir);
    chk("s7_at2", fl, 2);
    wait_close();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
